// File: rtl/bcd_down_counter_pkg.sv
// Shared BCD digit types and limits for the decade down counter.
package bcd_down_counter_pkg;

  localparam int BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  function automatic bcd_digit_t bcd_sat(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_down_counter_digit.sv
// One decade 9..0 with borrow; codes above 9 recover to 9.
// Optional parallel load under BCD_DOWN_COUNTER_LOAD_EN.
module bcd_digit_down
  import bcd_down_counter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       dec,
`ifdef BCD_DOWN_COUNTER_LOAD_EN
  input  logic       load,
  input  bcd_digit_t din,
`endif
  output bcd_digit_t digit,
  output logic       is_zero
);

  bcd_digit_t digit_q;
  bcd_digit_t digit_d;

  assign digit   = digit_q;
  assign is_zero = (digit_q == BCD_MIN);

  always_comb begin
    digit_d = digit_q;
    if (digit_q > BCD_MAX) begin
      digit_d = BCD_MAX;
    end else if (dec) begin
      digit_d = is_zero ? BCD_MAX : digit_q - 4'd1;
    end
`ifdef BCD_DOWN_COUNTER_LOAD_EN
    if (load) begin
      digit_d = bcd_sat(din);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digit_q <= BCD_MAX;
    end else begin
      digit_q <= digit_d;
    end
  end

endmodule

// File: rtl/bcd_down_counter.sv
// Cascaded BCD down counter, DIGITS decades, free running.
// BCD_DOWN_COUNTER_LOAD_EN adds load/din parallel load ports.
module bcd_down_counter
  import bcd_down_counter_pkg::*;
#(
  parameter int DIGITS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef BCD_DOWN_COUNTER_LOAD_EN
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   din,
`endif
  output logic [4*DIGITS-1:0]   q,
  output logic                  tc
);

  // dec_chain[k] = all digits below k are zero
  logic [DIGITS:0] dec_chain;
  logic [DIGITS-1:0] zero;

  assign dec_chain[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    bcd_digit_down u_digit (
      .clk     (clk),
      .rst     (rst),
      .dec     (dec_chain[i]),
`ifdef BCD_DOWN_COUNTER_LOAD_EN
      .load    (load),
      .din     (din[i*BCD_W +: BCD_W]),
`endif
      .digit   (q[i*BCD_W +: BCD_W]),
      .is_zero (zero[i])
    );
    assign dec_chain[i+1] = dec_chain[i] & zero[i];
  end

  assign tc = dec_chain[DIGITS];

endmodule

// File: tb/tb_bcd_down_counter.sv
// Scoreboard bench: 1-digit and 2-digit counters against
// decimal reference models.
module tb_bcd_down_counter;

  logic       clk;
  logic       rst;
  logic [3:0] q1;
  logic       tc1;
  logic [7:0] q2;
  logic       tc2;
`ifdef BCD_DOWN_COUNTER_LOAD_EN
  logic       load1;
  logic [3:0] din1;
  logic       load2;
  logic [7:0] din2;
`endif

  int checks = 0;
  int errors = 0;
  int m1;
  int m2;
  logic [13:0] sb_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bcd_down_counter #(.DIGITS(1)) dut1 (
    .clk  (clk),
    .rst  (rst),
`ifdef BCD_DOWN_COUNTER_LOAD_EN
    .load (load1),
    .din  (din1),
`endif
    .q    (q1),
    .tc   (tc1)
  );

  bcd_down_counter #(.DIGITS(2)) dut2 (
    .clk  (clk),
    .rst  (rst),
`ifdef BCD_DOWN_COUNTER_LOAD_EN
    .load (load2),
    .din  (din2),
`endif
    .q    (q2),
    .tc   (tc2)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd2(input int v);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  // r: reset, inv: corrupt digit 0 of dut1, ld/d: load into dut1
  task automatic step(input bit r, input bit inv, input bit ld,
                      input logic [3:0] d, input string tag);
    logic [13:0] e;
    logic [3:0]  e1;
    logic [7:0]  e2;
    @(negedge clk);
    rst = r;
`ifdef BCD_DOWN_COUNTER_LOAD_EN
    load1 = ld;
    din1  = d;
`endif
    if (inv) begin
      force dut1.g_dig[0].u_digit.digit_q = 4'hC;
      #1;
      release dut1.g_dig[0].u_digit.digit_q;
    end
    if (r)
      m1 = 9;
    else if (ld)
      m1 = (d > 4'd9) ? 9 : int'(d);
    else if (inv)
      m1 = 9;
    else
      m1 = (m1 == 0) ? 9 : m1 - 1;
    if (r)
      m2 = 99;
    else
      m2 = (m2 == 0) ? 99 : m2 - 1;
    e1 = 4'(m1);
    e2 = to_bcd2(m2);
    sb_q.push_back({e1, (m1 == 0), e2, (m2 == 0)});
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_q1"},  32'(q1),  32'(e[13:10]));
      chk({tag, "_tc1"}, 32'(tc1), 32'(e[9]));
      chk({tag, "_q2"},  32'(q2),  32'(e[8:1]));
      chk({tag, "_tc2"}, 32'(tc2), 32'(e[0]));
    end
  endtask

  initial begin
    rst = 1'b0;
    m1  = 0;
    m2  = 0;
`ifdef BCD_DOWN_COUNTER_LOAD_EN
    load1 = 1'b0;
    din1  = 4'd0;
    load2 = 1'b0;
    din2  = 8'd0;
`endif
    // reset then one full decade
    step(1, 0, 0, 4'd0, "rst");
    chk("rst_q1_9", 32'(q1), 32'h9);
    chk("rst_q2_99", 32'(q2), 32'h99);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 4'd0, "dec");
    chk("wrap_q1", 32'(q1), 32'h9);

    // mid-count reset
    step(1, 0, 0, 4'd0, "mid_rst0");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 4'd0, "mid");
    chk("mid_q1_6", 32'(q1), 32'h6);
    step(1, 0, 0, 4'd0, "mid_rst1");
    step(0, 0, 0, 4'd0, "mid_after");
    chk("mid_q1_8", 32'(q1), 32'h8);

    // long run: covers 99->90->89 and 00->99 on dut2
    step(1, 0, 0, 4'd0, "long_rst");
    for (int i = 0; i < 15; i++) step(0, 0, 0, 4'd0, "long15");
    chk("long_q1_4", 32'(q1), 32'h4);
    for (int i = 0; i < 150; i++) step(0, 0, 0, 4'd0, "long");

    // invalid code recovery
    step(0, 1, 0, 4'd0, "inv");
    chk("inv_q1_9", 32'(q1), 32'h9);
    step(0, 0, 0, 4'd0, "inv_after");

`ifdef BCD_DOWN_COUNTER_LOAD_EN
    step(0, 0, 1, 4'd3, "ld3");
    chk("ld3_q1", 32'(q1), 32'h3);
    step(0, 0, 0, 4'd0, "ld3_dec");
    chk("ld3_dec_q1", 32'(q1), 32'h2);
    step(0, 0, 1, 4'hF, "ldF");
    chk("ldF_q1", 32'(q1), 32'h9);
    step(0, 0, 1, 4'd0, "ld0");
    step(1, 0, 1, 4'd2, "rst_ld");
    chk("rst_ld_q1", 32'(q1), 32'h9);
    step(0, 0, 0, 4'd0, "ld_after");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
